// File: rtl/pipe_pkg.sv
// pipe_pkg: shared hazard/forwarding types and constants for the pipelined MIPS core
package pipe_pkg;
    localparam int TRK_AW = 8;
    localparam int FWD_RF  = 0;
    localparam int FWD_EX  = 1;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB  = 3;
    localparam int STG_ID  = 0;
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic [TRK_AW-1:0] dest;
    } track_entry_t;
    function automatic logic producer_hit(input track_entry_t e, input logic [TRK_AW-1:0] operand, input logic used);
        return used & e.valid & e.regwrite & (e.dest == operand) & (operand != '0);
    endfunction
endpackage

// File: rtl/pipe_fwd_match.sv
// pipe_fwd_match: youngest-producer search over the tracker for one EX operand
module pipe_fwd_match
    import pipe_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int SELW   = $clog2(NSTAGE + 1)
) (
    input  track_entry_t [NSTAGE-1:0] trk,
    input  logic [TRK_AW-1:0]         operand,
    input  logic                      used,
    output logic                      hit,
    output logic [SELW-1:0]           idx,
    output logic                      load
);
    // scan oldest to youngest so the youngest match overwrites older ones
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        load = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (producer_hit(trk[k], operand, used)) begin
                hit  = 1'b1;
                idx  = SELW'(k + 1);
                load = trk[k].memread;
            end
        end
    end
endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: load-use stall, branch flush and registered EX forwarding selects (optional HAZ_PERF_CNT_EN counters)
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int REG_AW   = 5,
    parameter int BR_STAGE = 2,
    parameter int SELW     = $clog2(NSTAGE + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic [REG_AW-1:0] id_dest_i,
    input  logic              br_taken_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic [SELW-1:0]   fwd_a_sel_o,
    output logic [SELW-1:0]   fwd_b_sel_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);
    track_entry_t [NSTAGE-1:0] trk;
    track_entry_t [NSTAGE-1:0] trk_nxt;
    logic                      hit_a, hit_b, load_a, load_b, issue;
    logic [SELW-1:0]           idx_a, idx_b, sel_a, sel_b;

    pipe_fwd_match #(.NSTAGE(NSTAGE), .SELW(SELW)) u_match_a (
        .trk(trk), .operand(TRK_AW'(id_rs_i)), .used(id_use_rs_i),
        .hit(hit_a), .idx(idx_a), .load(load_a)
    );

    pipe_fwd_match #(.NSTAGE(NSTAGE), .SELW(SELW)) u_match_b (
        .trk(trk), .operand(TRK_AW'(id_rt_i)), .used(id_use_rt_i),
        .hit(hit_b), .idx(idx_b), .load(load_b)
    );

    assign flush_o = br_taken_i;
    assign stall_o = id_valid_i & ~flush_o &
                     ((hit_a & load_a & (idx_a == SELW'(STG_EX))) |
                      (hit_b & load_b & (idx_b == SELW'(STG_EX))));
    assign issue   = id_valid_i & ~stall_o & ~flush_o;

    // next tracker contents, forwarding selects for the instruction entering EX
    always_comb begin
        sel_a      = (issue & hit_a & (idx_a < SELW'(NSTAGE))) ? idx_a + SELW'(1) : SELW'(FWD_RF);
        sel_b      = (issue & hit_b & (idx_b < SELW'(NSTAGE))) ? idx_b + SELW'(1) : SELW'(FWD_RF);
        trk_nxt[0] = '{valid: issue, regwrite: issue & id_regwrite_i,
                       memread: issue & id_memread_i, dest: TRK_AW'(id_dest_i)};
        for (int k = 1; k < NSTAGE; k++) begin
            trk_nxt[k]       = trk[k-1];
            trk_nxt[k].valid = trk[k-1].valid & ~(flush_o & (k + 1 < BR_STAGE));
        end
    end

    // tracker shift register and registered forwarding selects
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trk         <= '0;
            fwd_a_sel_o <= '0;
            fwd_b_sel_o <= '0;
        end else begin
            trk         <= trk_nxt;
            fwd_a_sel_o <= sel_a;
            fwd_b_sel_o <= sel_b;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // saturating event counters for stalls and flushes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            stall_cnt_o <= stall_cnt_o + 32'(stall_o & ~&stall_cnt_o);
            flush_cnt_o <= flush_cnt_o + 32'(flush_o & ~&flush_cnt_o);
        end
    end
`endif
endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the next-generation pipelined MIPS CPU. The current 5-stage core has no hazard handling.
- Sits beside the ID stage and tracks every in-flight instruction from EX to WB in an internal shift register.
- Generates load-use stalls, branch flushes and registered forwarding selects for the EX-stage ALU operands.

Parameters:
- NSTAGE, 3, tracked stages after ID (1=EX, 2=MEM, 3=WB); legal range 2..6.
- REG_AW, 5, register address width.
- BR_STAGE, 2, stage index where the branch resolves (2=MEM, as in the current core); legal range 1..NSTAGE-1.
- SELW, $clog2(NSTAGE+1), forwarding select width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i  in  REG_AW  rs field of the ID instruction
- id_rt_i  in  REG_AW  rt field of the ID instruction
- id_use_rs_i  in  1  instruction reads rs
- id_use_rt_i  in  1  instruction reads rt
- id_regwrite_i  in  1  decoder RegWrite
- id_memread_i  in  1  decoder MemRead (load)
- id_dest_i  in  REG_AW  destination after the RegDst mux, moved into ID
- br_taken_i  in  1  branch taken, from stage BR_STAGE
- stall_o  out  1  hold PC and IF/ID; insert bubble into ID/EX
- flush_o  out  1  kill IF/ID and every stage younger than BR_STAGE
- fwd_a_sel_o  out  SELW  EX operand A source: 0=register file, k=result of stage k
- fwd_b_sel_o  out  SELW  EX operand B source, same encoding

Behaviour:
- Tracker: NSTAGE entries {valid, regwrite, memread, dest}. Entry k describes the instruction currently in stage k.
- Every cycle the tracker shifts: entry k+1 <= entry k; entry NSTAGE retires.
- Entry 1 <= ID instruction when id_valid_i & !stall_o & !flush_o; otherwise a bubble (valid=0).
- A producer matches an operand when: valid & regwrite & dest==operand & dest!=0 & the matching use bit is set.
- stall_o (combinational) = id_valid_i & !flush_o & any operand matches entry 1 with memread=1 (load-use). Exactly one bubble is inserted per load-use.
- Forwarding selects are computed in ID and registered, so they are valid during the consumer's EX cycle.
  - If the youngest matching entry is k with k<NSTAGE, the select becomes k+1.
  - If there is no match, or only entry NSTAGE matches, the select becomes 0. The register file is write-first, so a WB producer is visible to ID.
  - The youngest match (smallest k) wins.
  - When the incoming instruction is a bubble, the registered selects are 0.
- flush_o = br_taken_i (combinational). On the next edge, entries 1..BR_STAGE-1 are invalidated after the shift and the ID instruction is discarded.
- flush_o wins over stall_o: stall_o is forced to 0 while flush_o=1.
- br_taken_i asserted in consecutive cycles: each assertion flushes independently.
- Reset (synchronous, may occur mid-operation): all tracker entries invalid, fwd_a/b_sel_o=0, counters=0. stall_o and flush_o then follow their inputs, so stall_o=0 with an empty tracker.
- Outputs depend only on the tracker and the current inputs; there are no X paths.

Optional Feature:
- HAZ_PERF_CNT_EN
- Defined:
  - Adds output ports stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - Each counter increments on every cycle its signal is 1, saturates at 32'hFFFF_FFFF and clears on rst_i.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - Forwarding-select encodings FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3.
  - Stage-index constants.
  - Packed struct track_entry_t {valid, regwrite, memread, dest}, shared with the future CPU top.
- Natural sub-module: pipe_fwd_match. It is combinational and instantiated once per operand; it performs the youngest-match priority search over the tracker and returns the match index plus the load flag.

Test Plan:
- Independent ops only, e.g. add $3,$1,$2; add $6,$4,$5 -> stall_o=0, fwd_a_sel_o=fwd_b_sel_o=0.
- Back-to-back ALU RAW, add $3,$1,$2 then sub $5,$3,$4 -> fwd_a_sel_o=2 in sub's EX cycle. Inserting one unrelated op between them -> fwd_a_sel_o=3.
- Load-use, lw $2,0($1) then add $4,$2,$2:
  - stall_o=1 for exactly 1 cycle.
  - Then fwd_a_sel_o=fwd_b_sel_o=3.
  - A bubble occupies EX during the stall.
- Writes to $0 (add $0,$1,$2 then add $3,$0,$0) -> no forwarding, fwd selects 0.
- br_taken_i=1 while a load-use stall is pending:
  - flush_o=1 and stall_o=0.
  - Entries 1..BR_STAGE-1 are invalid next cycle.
  - Repeat with NSTAGE=5, BR_STAGE=3.
- rst_i asserted while the tracker is full of RAW producers -> next cycle all selects 0 and no stall. With HAZ_PERF_CNT_EN, counters read 0 after reset and saturate when preloaded near the maximum.
